hilbert_frame_rx: RTL and testbench

Downstream receiver for the hilbert block's result interface. It captures each 32-sample complex frame announced by hilbert's RDY pulse and computes the per-sample magnitude-squared (envelope power). Frames go into a two-bank buffer and are re-issued as a valid/ready stream with index and last markers. This decouples the ED-gated transform output from a back-pressured consumer.

---
 rtl/hilbert_frame_rx.sv | 180 ++++++++++++++++++
 tb/tb_hilbert_frame_rx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilbert_frame_rx.sv
`default_nettype none
// ============================================================================
// hilbert_frame_rx : captures ED-gated hilbert frames into two banks and
//                    re-issues them with |x|^2 as a valid/ready stream.
// Revision: 1.0
// ============================================================================
module hilbert_frame_rx #(
    parameter int total_bits = 32,
    parameter int N          = 32,
    parameter int CAP_DELAY  = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         ED,
    input  logic                         RDY_IN,
    input  logic signed [total_bits-1:0] DIReal,
    input  logic signed [total_bits-1:0] DIImag,
    output logic                         OVALID,
    input  logic                         OREADY,
    output logic signed [total_bits-1:0] OREAL,
    output logic signed [total_bits-1:0] OIMAG,
    output logic [2*total_bits-1:0]      OMAG,
    output logic [$clog2(N)-1:0]         OIDX,
    output logic                         OLAST,
    output logic                         OVERRUN,
    output logic [15:0]                  FRAME_CNT
);
    localparam int IW = $clog2(N);
    localparam int DW = $clog2(CAP_DELAY + 1);
    localparam int MW = 2 * total_bits;
    localparam int EW = 2 * total_bits + MW;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [DW-1:0] ARM_LAST = DW'(CAP_DELAY - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARM = 2'd1, S_CAP = 2'd2} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] dcnt, dcnt_nx;
    logic [IW-1:0] widx, widx_nx;
    logic          wbank, wbank_nx;
    logic          last_wr, last_nx;
    logic [1:0]    full, full_eff, free_mask, set_mask;
    logic          cap_we, fill_done, ovr_set;

    logic [EW-1:0] mem [2][N];

    logic signed [MW-1:0] re_sq, im_sq;
    logic [MW-1:0]        mag_in;

    logic          rbank, out_bank;
    logic [IW-1:0] ridx;
    logic          take, load;

    assign re_sq  = MW'(DIReal) * MW'(DIReal);
    assign im_sq  = MW'(DIImag) * MW'(DIImag);
    assign mag_in = $unsigned(re_sq) + $unsigned(im_sq);

    assign take = OVALID & OREADY;
    assign load = full[rbank] & (~OVALID | OREADY);

    // A bank released by the drain this edge is already free for a new RDY_IN.
    always_comb begin
        free_mask = 2'b00;
        if (take && OLAST)
            free_mask[out_bank] = 1'b1;
        set_mask = 2'b00;
        if (fill_done)
            set_mask[wbank] = 1'b1;
        full_eff = full & ~free_mask;
    end

    always_comb begin
        state_nx  = state;
        dcnt_nx   = dcnt;
        widx_nx   = widx;
        wbank_nx  = wbank;
        last_nx   = last_wr;
        cap_we    = 1'b0;
        fill_done = 1'b0;
        ovr_set   = 1'b0;
        if (ED) begin
            unique case (state)
                S_IDLE: begin
                    if (RDY_IN) begin
                        if (!full_eff[~last_wr]) begin
                            state_nx = S_ARM;
                            dcnt_nx  = DW'(1);
                            wbank_nx = ~last_wr;
                            last_nx  = ~last_wr;
                        end else if (!full_eff[last_wr]) begin
                            state_nx = S_ARM;
                            dcnt_nx  = DW'(1);
                            wbank_nx = last_wr;
                        end else begin
                            ovr_set = 1'b1;
                        end
                    end
                end
                S_ARM, S_CAP: begin
                    if (RDY_IN) begin
                        ovr_set  = 1'b1;
                        state_nx = S_ARM;
                        dcnt_nx  = DW'(1);
                    end else if (state == S_ARM) begin
                        dcnt_nx = dcnt + 1'b1;
                        if (dcnt >= ARM_LAST) begin
                            state_nx = S_CAP;
                            widx_nx  = '0;
                        end
                    end else begin
                        cap_we  = 1'b1;
                        widx_nx = widx + 1'b1;
                        if (widx == IDX_LAST) begin
                            fill_done = 1'b1;
                            state_nx  = S_IDLE;
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            dcnt      <= '0;
            widx      <= '0;
            wbank     <= 1'b0;
            last_wr   <= 1'b1;
            full      <= 2'b00;
            OVERRUN   <= 1'b0;
            FRAME_CNT <= '0;
        end else begin
            state   <= state_nx;
            dcnt    <= dcnt_nx;
            widx    <= widx_nx;
            wbank   <= wbank_nx;
            last_wr <= last_nx;
            full    <= full_eff | set_mask;
            if (ovr_set)
                OVERRUN <= 1'b1;
            if (fill_done)
                FRAME_CNT <= FRAME_CNT + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (cap_we)
            mem[wbank][widx] <= {DIReal, DIImag, mag_in};
    end

    // ridx/rbank point at the next entry to load, so a new frame follows OLAST without a bubble.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OVALID   <= 1'b0;
            OREAL    <= '0;
            OIMAG    <= '0;
            OMAG     <= '0;
            OIDX     <= '0;
            OLAST    <= 1'b0;
            out_bank <= 1'b0;
            rbank    <= 1'b0;
            ridx     <= '0;
        end else if (load) begin
            {OREAL, OIMAG, OMAG} <= mem[rbank][ridx];
            OIDX     <= ridx;
            OLAST    <= (ridx == IDX_LAST);
            out_bank <= rbank;
            OVALID   <= 1'b1;
            ridx     <= ridx + 1'b1;
            if (ridx == IDX_LAST)
                rbank <= ~rbank;
        end else if (take) begin
            OVALID <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilbert_frame_rx.sv
`default_nettype none
// tb_hilbert_frame_rx : directed scenarios with random frame data, checked
// against a queue of expected output beats built from the frame contents.
module tb_hilbert_frame_rx;
    localparam int W  = 32;
    localparam int NS = 32;

    logic                CLK = 1'b0;
    logic                RST, ED, RDY_IN, OREADY;
    logic signed [W-1:0] DIReal, DIImag, OREAL, OIMAG;
    logic [2*W-1:0]      OMAG;
    logic [4:0]          OIDX;
    logic                OVALID, OLAST, OVERRUN;
    logic [15:0]         FRAME_CNT;

    typedef struct packed {
        logic [W-1:0]   re;
        logic [W-1:0]   im;
        logic [2*W-1:0] mag;
        logic [4:0]     idx;
        logic           last;
    } beat_t;

    beat_t exp_q[$];
    int    fr_re[NS];
    int    fr_im[NS];
    int    vectors    = 0;
    int    errs       = 0;
    int    exp_frames = 0;
    logic  exp_ovr    = 1'b0;

    hilbert_frame_rx #(.total_bits(W), .N(NS), .CAP_DELAY(2)) dut (
        .CLK(CLK), .RST(RST), .ED(ED), .RDY_IN(RDY_IN),
        .DIReal(DIReal), .DIImag(DIImag),
        .OVALID(OVALID), .OREADY(OREADY),
        .OREAL(OREAL), .OIMAG(OIMAG), .OMAG(OMAG),
        .OIDX(OIDX), .OLAST(OLAST),
        .OVERRUN(OVERRUN), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input beat_t obs, input beat_t exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL beat observed=%h expected=%h", obs, exp);
        end
    endtask

    function automatic logic [63:0] model_mag(input int re, input int im);
        longint a, b;
        logic [63:0] sa, sb;
        a  = re;
        b  = im;
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        sa = a * a;
        sb = b * b;
        return sa + sb;
    endfunction

    task automatic push_frame();
        beat_t b;
        for (int n = 0; n < NS; n++) begin
            b.re   = fr_re[n];
            b.im   = fr_im[n];
            b.mag  = model_mag(fr_re[n], fr_im[n]);
            b.idx  = 5'(n);
            b.last = (n == NS - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic rand_frame();
        for (int n = 0; n < NS; n++) begin
            fr_re[n] = $urandom;
            fr_im[n] = $urandom;
        end
    endtask

    // Sample n goes on the ED-qualified edge n+2 after the RDY edge.
    task automatic send_frame(input int nsamp, input bit tog);
        int k;
        bit phase;
        ED     = 1'b1;
        RDY_IN = 1'b1;
        DIReal = $urandom;
        DIImag = $urandom;
        step();
        RDY_IN = 1'b0;
        k      = 1;
        phase  = 1'b0;
        while (k < nsamp + 2) begin
            if (tog && phase) begin
                ED     = 1'b0;
                DIReal = $urandom;
                DIImag = $urandom;
                step();
                phase = 1'b0;
            end else begin
                ED = 1'b1;
                if (k >= 2) begin
                    DIReal = fr_re[k-2];
                    DIImag = fr_im[k-2];
                end else begin
                    DIReal = $urandom;
                    DIImag = $urandom;
                end
                step();
                k++;
                phase = tog;
            end
        end
        ED = 1'b1;
    endtask

    task automatic drain(input bit rand_ready, input bit rand_ed, input int budget);
        beat_t obs;
        for (int cyc = 0; cyc < budget && exp_q.size() > 0; cyc++) begin
            OREADY = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rand_ed)
                ED = $urandom_range(0, 1);
            if (OVALID) begin
                obs = {OREAL, OIMAG, OMAG, OIDX, OLAST};
                chk_beat(obs, exp_q[0]);
                if (OREADY)
                    void'(exp_q.pop_front());
            end
            step();
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk("valid_drop", 64'(OVALID), 64'd0);
        ED     = 1'b1;
        OREADY = 1'b1;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_frame_cnt"}, 64'(FRAME_CNT), 64'(exp_frames[15:0]));
        chk({tag, "_overrun"}, 64'(OVERRUN), 64'(exp_ovr));
    endtask

    initial begin
        beat_t b;
        RST = 1'b1; ED = 1'b0; RDY_IN = 1'b0; OREADY = 1'b1;
        DIReal = '0; DIImag = '0;
        step();
        step();
        chk("rst_ovalid", 64'(OVALID), 64'd0);
        chk("rst_omag", OMAG, 64'd0);
        chk("rst_oidx", 64'(OIDX), 64'd0);
        chk_status("rst");
        RST = 1'b0;
        ED  = 1'b1;
        step();

        // Single frame: re=n, im=-n, plus first-OVALID latency.
        for (int n = 0; n < NS; n++) begin
            fr_re[n] = n;
            fr_im[n] = -n;
        end
        send_frame(NS, 1'b0);
        push_frame();
        exp_frames++;
        chk("lat_pre", 64'(OVALID), 64'd0);
        step();
        chk("lat_first", 64'(OVALID), 64'd1);
        chk_status("single");
        drain(1'b0, 1'b0, 200);

        // Magnitude corners with hand-computed constants.
        rand_frame();
        fr_re[0] = 3;            fr_im[0] = -4;
        fr_re[1] = 32'h80000000; fr_im[1] = 32'h80000000;
        fr_re[2] = 32'h7fffffff; fr_im[2] = 0;
        send_frame(NS, 1'b0);
        push_frame();
        exp_frames++;
        b = exp_q[0]; b.mag = 64'd25;                  exp_q[0] = b;
        b = exp_q[1]; b.mag = 64'h8000_0000_0000_0000; exp_q[1] = b;
        b = exp_q[2]; b.mag = 64'h3fff_ffff_0000_0001; exp_q[2] = b;
        drain(1'b1, 1'b1, 400);
        chk_status("corner");

        // ED toggling during capture.
        rand_frame();
        send_frame(NS, 1'b1);
        push_frame();
        exp_frames++;
        drain(1'b1, 1'b1, 400);
        chk_status("edtog");

        // Back-pressure: two frames stored, third dropped.
        OREADY = 1'b0;
        rand_frame(); send_frame(NS, 1'b0); push_frame(); exp_frames++;
        rand_frame(); send_frame(NS, 1'b0); push_frame(); exp_frames++;
        chk("bp_valid", 64'(OVALID), 64'd1);
        chk_status("bp_two");
        rand_frame(); send_frame(NS, 1'b0);
        exp_ovr = 1'b1;
        chk_status("bp_drop");
        drain(1'b0, 1'b0, 400);

        // Truncation: second RDY_IN at widx=10.
        RST = 1'b1; step(); RST = 1'b0;
        exp_frames = 0; exp_ovr = 1'b0;
        chk_status("trunc_rst");
        rand_frame(); send_frame(10, 1'b0);
        rand_frame(); send_frame(NS, 1'b0); push_frame(); exp_frames++;
        exp_ovr = 1'b1;
        chk_status("trunc");
        drain(1'b1, 1'b0, 400);

        // Reset mid-capture with one buffered frame pending.
        OREADY = 1'b0;
        rand_frame(); send_frame(NS, 1'b0);
        rand_frame(); send_frame(15, 1'b0);
        RST = 1'b1; step(); step(); RST = 1'b0;
        exp_frames = 0; exp_ovr = 1'b0;
        chk("mrst_ovalid", 64'(OVALID), 64'd0);
        chk_status("mrst");
        OREADY = 1'b1;
        rand_frame(); send_frame(NS, 1'b0); push_frame(); exp_frames++;
        drain(1'b0, 1'b0, 200);
        chk_status("mrst_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
